// File: rtl/lsu_mem_master.sv
// Load/store unit: turns core byte/half/word accesses into word-wide memory
// transactions with byte enables, stalling the core until memory answers.
module lsu_mem_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_req_o,
   output logic        core_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   // state | meaning
   // IDLE  | no transaction; a legal request is accepted in one cycle
   // BUSY  | memory request held from latched fields until ready or timeout
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [2:0]  size_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wd_q;

   logic        size_ok;
   logic        aligned;
   logic        accept;
   logic [3:0]  be_new;
   logic [31:0] wd_new;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;

   always_comb begin
      size_ok = (core_size_i == 3'd0) || (core_size_i == 3'd1) || (core_size_i == 3'd2) ||
                (core_size_i == 3'd4) || (core_size_i == 3'd5);
      case (core_size_i[1:0])
         2'd1:    aligned = ~core_addr_i[0];
         2'd2:    aligned = (core_addr_i[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   always_comb begin
      case (core_size_i[1:0])
         2'd0: begin
            be_new = 4'b0001 << core_addr_i[1:0];
            wd_new = {4{core_wd_i[7:0]}};
         end
         2'd1: begin
            be_new = core_addr_i[1] ? 4'b1100 : 4'b0011;
            wd_new = {2{core_wd_i[15:0]}};
         end
         default: begin
            be_new = 4'b1111;
            wd_new = core_wd_i;
         end
      endcase
   end

   // Lane selection uses the latched offset; mem_rd_i is only meaningful with ready.
   always_comb begin
      byte_sel = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      case (size_q)
         3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
         3'd4:    load_val = {24'd0, byte_sel};
         3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
         3'd5:    load_val = {16'd0, half_sel};
         default: load_val = mem_rd_i;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      accept           = 1'b0;
      core_rd_o        = 32'd0;
      core_stall_req_o = 1'b0;
      core_err_o       = 1'b0;
      mem_req_o        = 1'b0;
      mem_we_o         = 1'b0;
      mem_be_o         = 4'd0;
      mem_addr_o       = 32'd0;
      mem_wd_o         = 32'd0;
      case (state_q)
         IDLE: begin
            if (core_req_i) begin
               if (size_ok && aligned) begin
                  accept           = 1'b1;
                  state_d          = BUSY;
                  cnt_d            = 8'd0;
                  core_stall_req_o = 1'b1;
               end else begin
                  core_err_o = 1'b1;
               end
            end
         end
         BUSY: begin
            mem_req_o  = 1'b1;
            mem_we_o   = we_q;
            mem_be_o   = be_q;
            mem_addr_o = addr_q;
            mem_wd_o   = wd_q;
            if (mem_ready_i) begin
               state_d = IDLE;
               if (core_req_i && !we_q) core_rd_o = load_val;
            end else if (cnt_q == TERM_CNT) begin
               state_d    = IDLE;
               core_err_o = core_req_i;
            end else begin
               cnt_d            = cnt_q + 8'd1;
               core_stall_req_o = core_req_i;
            end
         end
         default: state_d = IDLE;
      endcase
      // Core-facing handshakes stay quiet while reset is held, even with a request pending.
      if (!rst_ni) begin
         core_stall_req_o = 1'b0;
         core_err_o       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         we_q    <= 1'b0;
         size_q  <= 3'd0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wd_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            be_q   <= be_new;
            wd_q   <= wd_new;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and randomized checks of lsu_mem_master against a byte-array
// memory model and arithmetic lane/extension rules.
module tb_lsu_mem_master;

   logic        clk;
   logic        rst_n;
   logic        core_req;
   logic        core_we;
   logic [2:0]  core_size;
   logic [31:0] core_addr;
   logic [31:0] core_wd;
   logic [31:0] core_rd;
   logic        core_stall_req;
   logic        core_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_ready;

   int vectors;
   int miscompares;

   logic [7:0] mem_b [0:255];
   logic [2:0] sz_tab [13];

   lsu_mem_master #(.TIMEOUT(16)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .core_req_i       (core_req),
      .core_we_i        (core_we),
      .core_size_i      (core_size),
      .core_addr_i      (core_addr),
      .core_wd_i        (core_wd),
      .core_rd_o        (core_rd),
      .core_stall_req_o (core_stall_req),
      .core_err_o       (core_err),
      .mem_req_o        (mem_req),
      .mem_we_o         (mem_we),
      .mem_be_o         (mem_be),
      .mem_addr_o       (mem_addr),
      .mem_wd_o         (mem_wd),
      .mem_rd_i         (mem_rd),
      .mem_ready_i      (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   function automatic int nbytes(input logic [2:0] size);
      return 1 << size[1:0];
   endfunction

   function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
      bit ok_size;
      ok_size = (size == 3'd0) || (size == 3'd1) || (size == 3'd2) || (size == 3'd4) || (size == 3'd5);
      return ok_size && ((addr % nbytes(size)) == 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] addr);
      int mask;
      mask = ((1 << nbytes(size)) - 1) << (addr % 4);
      return 4'(mask);
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] size, input logic [31:0] wd);
      case (nbytes(size))
         1:       return (wd & 32'hFF) * 32'h01010101;
         2:       return (wd & 32'hFFFF) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      int b;
      b = addr & 32'hFC;
      return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] size, input logic [31:0] addr,
                                            input logic [31:0] word);
      logic [31:0] v, m;
      int bits;
      if (nbytes(size) == 4) return word;
      bits = 8 * nbytes(size);
      m = (32'd1 << bits) - 32'd1;
      v = (word >> (8 * (addr % 4))) & m;
      if (!size[2] && v[bits-1]) v = v | ~m;
      return v;
   endfunction

   task automatic idle();
      next_cycle();
      core_req  = 1'b0;
      mem_ready = 1'b0;
      mem_rd    = $urandom;
      settle();
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_stall", 32'(core_stall_req), 32'd0);
      chk("idle_rd", core_rd, 32'd0);
   endtask

   // One access; lat = number of BUSY cycles before the one that sees ready.
   task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
      logic [31:0] word;
      next_cycle();
      core_req  = 1'b1;
      core_we   = we;
      core_size = size;
      core_addr = addr;
      core_wd   = wd;
      mem_ready = 1'b0;
      mem_rd    = $urandom;
      settle();
      chk("acc_req", 32'(mem_req), 32'd0);
      chk("acc_rd", core_rd, 32'd0);
      if (!is_legal(size, addr)) begin
         chk("bad_err", 32'(core_err), 32'd1);
         chk("bad_stall", 32'(core_stall_req), 32'd0);
         return;
      end
      chk("acc_err", 32'(core_err), 32'd0);
      chk("acc_stall", 32'(core_stall_req), 32'd1);
      word = model_word(addr);
      for (int k = 0; k <= lat; k++) begin
         next_cycle();
         mem_ready = (k == lat);
         mem_rd    = (k == lat) ? word : $urandom;
         settle();
         chk("busy_req", 32'(mem_req), 32'd1);
         chk("busy_we", 32'(mem_we), 32'(we));
         chk("busy_be", 32'(mem_be), 32'(exp_be(size, addr)));
         chk("busy_addr", mem_addr, addr);
         chk("busy_wd", mem_wd, exp_wd(size, wd));
         chk("busy_stall", 32'(core_stall_req), (k == lat) ? 32'd0 : 32'd1);
         chk("busy_err", 32'(core_err), 32'd0);
         chk("busy_rd", core_rd, (k == lat && !we) ? exp_load(size, addr, word) : 32'd0);
      end
      if (we) begin
         for (int i = 0; i < nbytes(size); i++) mem_b[(addr + i) & 32'hFF] = wd[8*i +: 8];
      end
   endtask

   task automatic poke_word(input logic [31:0] addr, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem_b[(addr & 32'hFC) + i] = w[8*i +: 8];
   endtask

   initial begin
      logic [2:0]  sz;
      logic [31:0] ad;
      vectors     = 0;
      miscompares = 0;
      sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
      rst_n     = 1'b0;
      core_req  = 1'b0;
      core_we   = 1'b0;
      core_size = 3'd0;
      core_addr = 32'd0;
      core_wd   = 32'd0;
      mem_rd    = 32'd0;
      mem_ready = 1'b0;
      settle();
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wd", mem_wd, 32'd0);
      chk("rst_rd", core_rd, 32'd0);
      chk("rst_err", 32'(core_err), 32'd0);
      chk("rst_stall", 32'(core_stall_req), 32'd0);
      settle();
      rst_n = 1'b1;
      idle();

      access(1'b1, 3'd2, 32'h4, 32'hABCDEF90, 1);
      idle();
      access(1'b0, 3'd2, 32'h4, 32'h0, 2);
      access(1'b1, 3'd1, 32'h6, 32'h12345678, 0);
      access(1'b0, 3'd5, 32'h6, 32'h0, 1);
      poke_word(32'h4, 32'h80011234);
      access(1'b0, 3'd1, 32'h6, 32'h0, 0);
      access(1'b1, 3'd0, 32'h5, 32'h777777CE, 0);
      poke_word(32'h4, 32'h0000CE00);
      access(1'b0, 3'd0, 32'h5, 32'h0, 0);
      access(1'b0, 3'd4, 32'h5, 32'h0, 0);
      access(1'b0, 3'd2, 32'h2, 32'h0, 0);
      idle();
      access(1'b0, 3'd1, 32'h3, 32'h0, 0);
      access(1'b0, 3'd3, 32'h8, 32'h0, 0);
      idle();

      // Timeout: 16 BUSY cycles with no ready.
      next_cycle();
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_size = 3'd2;
      core_addr = 32'h10;
      mem_ready = 1'b0;
      settle();
      chk("to_accept_stall", 32'(core_stall_req), 32'd1);
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         settle();
         chk("to_req", 32'(mem_req), 32'd1);
         chk("to_stall", 32'(core_stall_req), (k < 15) ? 32'd1 : 32'd0);
         chk("to_err", 32'(core_err), (k == 15) ? 32'd1 : 32'd0);
      end
      idle();
      chk("to_err_after", 32'(core_err), 32'd0);
      access(1'b0, 3'd2, 32'h10, 32'h0, 15);
      idle();

      // Reset in the middle of a load completion cycle.
      next_cycle();
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_size = 3'd2;
      core_addr = 32'h4;
      settle();
      next_cycle();
      settle();
      chk("mid_req", 32'(mem_req), 32'd1);
      #1;
      mem_ready = 1'b1;
      mem_rd    = 32'h12345678;
      rst_n     = 1'b0;
      #1;
      chk("mid_rst_req", 32'(mem_req), 32'd0);
      chk("mid_rst_stall", 32'(core_stall_req), 32'd0);
      chk("mid_rst_rd", core_rd, 32'd0);
      chk("mid_rst_err", 32'(core_err), 32'd0);
      core_req  = 1'b0;
      mem_ready = 1'b0;
      settle();
      settle();
      rst_n = 1'b1;
      access(1'b1, 3'd2, 32'h4, 32'hCAFEF00D, 1);
      access(1'b0, 3'd2, 32'h4, 32'h0, 0);
      idle();

      for (int n = 0; n < 60; n++) begin
         sz = sz_tab[$urandom_range(0, 12)];
         ad = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) ad = ad & ~32'(nbytes(sz) - 1) & 32'hFC;
         access(1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom_range(0, 4));
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: simulation did not finish, observed timeout expected completion");
   end

endmodule
